tsmac_txbuf_reader: RTL
=======================

Name: tsmac_txbuf_reader

Overview:
- Read-side controller for the TSMAC transmit frame buffer.
- The host-side writer fills a dual-port DRM18K-based RAM on port A and posts one length descriptor per frame.
- This block drives port B, streams each frame byte-wise to the MAC TX with sop/eop framing, and returns freed buffer space to the writer.
- It hides the RAM read latency behind a small skid FIFO, so backpressure is lossless and throughput is one beat per cycle.

Parameters:
- ADDR_WIDTH, 11, RAM address width; the buffer is a circular region of 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, width of a RAM word and of a TX beat.
- RD_LATENCY, 1, cycles from ram_ce to valid ram_q. 1 = no output register, 2 = output register enabled. Only 1 and 2 are legal.

Ports:
- clk  in  1  single clock for RAM port B and the TX stream.
- rst_n  in  1  asynchronous active-low reset.
- desc_valid  in  1  a frame descriptor is available.
- desc_len  in  ADDR_WIDTH+1  frame length in entries, 0..2^ADDR_WIDTH.
- desc_ready  out  1  descriptor accepted when desc_valid&desc_ready.
- ram_addr  out  ADDR_WIDTH  RAM port B read address.
- ram_ce  out  1  RAM port B read enable.
- ram_q  in  DATA_WIDTH  RAM port B read data.
- tx_data  out  DATA_WIDTH  output beat.
- tx_valid  out  1  beat valid.
- tx_sop  out  1  first beat of a frame; qualified by tx_valid.
- tx_eop  out  1  last beat of a frame; qualified by tx_valid.
- tx_ready  in  1  sink accepts the beat.
- free_ptr  out  ADDR_WIDTH  start address of the oldest unsent frame; the writer uses it for its full computation.
- frame_done  out  1  one-cycle pulse when a frame's last beat is accepted.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, rd_ptr=0, skid FIFO empty, in-flight count 0.
- States:
  - IDLE: desc_ready=1. On handshake, latch remaining=desc_len, set first=1.
    - desc_len!=0: go to READ.
    - desc_len==0: descriptor consumed, no beats, no frame_done, stay IDLE.
  - READ: desc_ready=0.
    - Issue a read (ram_ce=1, ram_addr=rd_ptr) when remaining>0 and skid_count+inflight < RD_LATENCY+2, with pops in the same cycle counted.
    - Each issue: rd_ptr+1 modulo 2^ADDR_WIDTH (wraps silently), remaining-1.
    - When the final read is issued, go to DRAIN.
  - DRAIN: no reads issued. When the eop beat is handshaked, pulse frame_done, set free_ptr=rd_ptr, go to IDLE.
- Read-data capture: ram_q is pushed into the skid FIFO RD_LATENCY cycles after its ram_ce. Each entry carries sop, set on the first read of the frame, and eop, set on the read issued with remaining==1.
- Skid FIFO: depth RD_LATENCY+2. Registered output drives tx_data/tx_valid/tx_sop/tx_eop. Overflow is structurally impossible because of the credit check; verification asserts it.
- Latency: descriptor accepted at cycle T → first ram_ce at T+1 → tx_valid at T+2+RD_LATENCY.
- Throughput: with tx_ready held high, one beat per cycle with no gaps within a frame.
- Handshake rules:
  - Beat transfers on tx_valid&tx_ready.
  - Once tx_valid is high, tx_data, tx_sop and tx_eop are held stable until accepted.
  - tx_valid does not depend combinationally on tx_ready.
- Single-entry frame: tx_sop and tx_eop are asserted on the same beat.
- Back-to-back frames: the next descriptor is accepted only in IDLE. There is a minimum 1-cycle gap between frame_done and the next frame's first ram_ce.
- Simultaneous push and pop on the skid FIFO: both take effect; count is unchanged.
- Reset mid-frame: everything returns to reset values immediately. Partially sent frame data is discarded and the sink sees no eop. The writer's pointers are reset by the same rst_n.
- free_ptr changes only on frame_done.

Decomposition:
- Shared package tsmac_txbuf_pkg: state enum (IDLE/READ/DRAIN), skid entry struct {data, sop, eop}, and the function that computes skid depth from RD_LATENCY.
- One sub-module, tsmac_skid_fifo: parameterised-depth synchronous FIFO with registered output, count, and a push/pop-same-cycle rule.

Test Plan:
- RD_LATENCY=1, desc_len=4 at addr 0, RAM holds 0x11,0x22,0x33,0x44, tx_ready=1 → beats on 4 consecutive cycles starting T+3; sop on 0x11, eop on 0x44; frame_done one cycle later; free_ptr=4.
- RD_LATENCY=2, same frame, tx_ready toggled 1,0,0,1,… → all 4 bytes delivered in order with no loss or duplication; data held stable while tx_ready=0; ram_ce stalls when skid_count+inflight reaches 4.
- Wrap: preload rd_ptr=2046 via a prior 2046-entry frame, then desc_len=4 → ram_addr sequence 2046, 2047, 0, 1; free_ptr=2.
- Frame lengths 1, then 0, then 3 back-to-back → single beat with sop=eop=1; zero-length descriptor consumed silently; third frame sop/eop correct; frame_done pulsed exactly twice.
- desc_len=2048 (full buffer) → 2048 beats; free_ptr returns to its start value.
- Assert rst_n low mid-DRAIN of an 8-entry frame → tx_valid=0, desc_ready=0, and free_ptr=0 within the reset cycle; after release the next frame reads from addr 0.

Source files
------------

// File: rtl/tsmac_txbuf_pkg.sv
// rtl/tsmac_txbuf_pkg.sv - shared types and helpers for the TSMAC transmit buffer reader
//
// Contents:
//   state_t       reader control states (IDLE / READ / DRAIN)
//   beat_flags_t  framing flags carried with every skid entry
//   skid_depth()  skid FIFO depth needed to hide a given RAM read latency

package tsmac_txbuf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // A skid entry is {data, flags}. The data field is sized by the top-level
   // DATA_WIDTH parameter, so only the fixed-width flags live here as a type.
   typedef struct packed {
      logic sop;
      logic eop;
   } beat_flags_t;

   localparam int FLAG_BITS = $bits(beat_flags_t);

   // One slot per cycle of read latency plus two: one for the registered
   // output beat and one so a pop and a new issue can overlap without a bubble.
   function automatic int skid_depth(input int rd_latency);
      return rd_latency + 2;
   endfunction

endpackage

// File: rtl/tsmac_skid_fifo.sv
// rtl/tsmac_skid_fifo.sv - small synchronous FIFO with registered output and occupancy count
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data this cycle
//   push_data    entry to store
//   pop          consume the head entry (ignored when empty)
//   head         current head entry, forced to 0 when empty
//   valid        FIFO holds at least one entry
//   count        number of stored entries

module tsmac_skid_fifo #(
   parameter int  WIDTH = 10,
   parameter int  DEPTH = 3,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic             do_pop;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   assign head   = valid ? mem[rd_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_idx <= next_idx(wr_idx);
         if (do_pop)
            rd_idx <= next_idx(rd_idx);
         // Push and pop together leave the count unchanged.
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/tsmac_txbuf_reader.sv
// rtl/tsmac_txbuf_reader.sv - read side of the TSMAC TX frame buffer, streams frames to the MAC
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   desc_valid/desc_len/desc_ready   frame length descriptors from the writer
//   ram_addr, ram_ce, ram_q     RAM port B read interface (RD_LATENCY cycles)
//   tx_data/tx_valid/tx_sop/tx_eop/tx_ready   byte stream to the MAC
//   free_ptr                    start of the oldest unsent frame, for the writer
//   frame_done                  one-cycle pulse after a frame's last beat is taken

module tsmac_txbuf_reader
   import tsmac_txbuf_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  desc_valid,
   input  logic [ADDR_WIDTH:0]   desc_len,
   output logic                  desc_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_ce,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_sop,
   output logic                  tx_eop,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] free_ptr,
   output logic                  frame_done
);

   localparam int DEPTH = skid_depth(RD_LATENCY);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int EW    = DATA_WIDTH + FLAG_BITS;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  first;
   logic                  run;
   logic [RD_LATENCY-1:0] ce_pipe;
   logic [RD_LATENCY-1:0] sop_pipe;
   logic [RD_LATENCY-1:0] eop_pipe;
   logic                  issue;
   logic                  desc_fire;
   logic                  pop;
   logic                  push;
   logic                  credit_ok;
   logic [CW-1:0]         skid_count;
   logic [CW:0]           occupancy;
   logic [EW-1:0]         push_data;
   logic [EW-1:0]         head;
   beat_flags_t           push_flags;
   beat_flags_t           head_flags;

   assign desc_fire = desc_valid && desc_ready;
   assign pop       = tx_valid && tx_ready;
   assign ram_ce    = issue;
   assign ram_addr  = rd_ptr;

   // Every issued read owns a skid slot from issue until its beat is popped,
   // so skid occupancy plus reads still in the RAM pipe can never exceed DEPTH.
   always_comb begin
      occupancy = {1'b0, skid_count};
      for (int i = 0; i < RD_LATENCY; i++)
         occupancy = occupancy + (CW + 1)'(ce_pipe[i]);
      occupancy = occupancy - (CW + 1)'(pop);
   end

   assign credit_ok = (occupancy < (CW + 1)'(DEPTH));

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      desc_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            // run holds desc_ready low for the first cycle after reset release.
            desc_ready = run;
            if (desc_valid && run && (desc_len != '0))
               state_nxt = ST_READ;
         end
         ST_READ: begin
            issue = (remaining != '0) && credit_ok;
            if (issue && (remaining == (ADDR_WIDTH + 1)'(1)))
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop && tx_eop)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         run        <= 1'b0;
         rd_ptr     <= '0;
         remaining  <= '0;
         first      <= 1'b0;
         free_ptr   <= '0;
         frame_done <= 1'b0;
         ce_pipe    <= '0;
         sop_pipe   <= '0;
         eop_pipe   <= '0;
      end else begin
         state      <= state_nxt;
         run        <= 1'b1;
         frame_done <= 1'b0;
         if (desc_fire) begin
            remaining <= desc_len;
            first     <= 1'b1;
         end
         if (issue) begin
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            first     <= 1'b0;
         end
         if ((state == ST_DRAIN) && pop && tx_eop) begin
            frame_done <= 1'b1;
            free_ptr   <= rd_ptr;
         end
         // Framing flags travel alongside the read so they meet ram_q on push.
         ce_pipe[0]  <= issue;
         sop_pipe[0] <= issue && first;
         eop_pipe[0] <= issue && (remaining == (ADDR_WIDTH + 1)'(1));
         for (int i = 1; i < RD_LATENCY; i++) begin
            ce_pipe[i]  <= ce_pipe[i-1];
            sop_pipe[i] <= sop_pipe[i-1];
            eop_pipe[i] <= eop_pipe[i-1];
         end
      end
   end

   assign push           = ce_pipe[RD_LATENCY-1];
   assign push_flags.sop = sop_pipe[RD_LATENCY-1];
   assign push_flags.eop = eop_pipe[RD_LATENCY-1];
   assign push_data      = {ram_q, push_flags};

   tsmac_skid_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (tx_valid),
      .count     (skid_count)
   );

   assign tx_data    = head[EW-1:FLAG_BITS];
   assign head_flags = head[FLAG_BITS-1:0];
   assign tx_sop     = head_flags.sop;
   assign tx_eop     = head_flags.eop;

endmodule
